multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the write enables and mux selects for the PC, IR, register file, data memory, ALU and the immediate extender. It sits beside the datapath, reads opcode/funct from the IR and the ALU zero flag, and is the only source of control in the CPU.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; returns FSM to FETCH
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH until the next FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0, valid in BRANCH state
- pc_we  out  1  PC register write enable
- ir_we  out  1  IR write enable
- npc_sel  out  2  00 PC+4, 01 PC+(sext(imm)<<2), 10 {PC[31:28],imm26,00}, 11 GPR[rs]; computed from the current PC register
- ext_op  out  1  extender mode: 1 sign-extend, 0 zero-extend
- alu_src_b  out  1  0 GPR[rt], 1 extended immediate
- alu_op  out  2  00 ADD, 01 SUB, 10 OR, 11 LUI (B<<16)
- mem_we  out  1  data memory write enable
- reg_we  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU result register, 01 memory data register, 10 PC register
- retire  out  1  high in the last cycle of every instruction
- state  out  4  current state encoding, for debug/verification

## Operation
- Decoded classes: R-type (opcode 000000) with funct 100000 add, 100010 sub, 001000 jr. I-type ori 001101, lui 001111, lw 100011, sw 101011, beq 000100. J-type jal 000011. Any other opcode/funct, including all-zero nop, is UNKNOWN.
- States and encodings: FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, JR 11. Encodings 12-15 are illegal and go to FETCH on the next edge.
- FETCH: ir_we=1, pc_we=1, npc_sel=00. Next state DECODE.
- DECODE: no enables. Next state by class: add/sub→EXE_R; ori/lui→EXE_I; lw/sw→MEM_ADDR; beq→BRANCH; jal→JUMP; jr→JR; UNKNOWN→FETCH with retire=1.
- EXE_R: alu_src_b=0, alu_op = 00 (add) or 01 (sub). Next state WB_ALU.
- EXE_I: alu_src_b=1, ext_op=0, alu_op = 10 (ori) or 11 (lui). Next state WB_ALU.
- WB_ALU: reg_we=1, wd_sel=00, reg_dst = 01 for R-type and 00 for I-type; retire=1. Next state FETCH.
- MEM_ADDR: alu_src_b=1, ext_op=1, alu_op=00. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: no enables. Next state WB_MEM.
- WB_MEM: reg_we=1, reg_dst=00, wd_sel=01, retire=1. Next state FETCH.
- MEM_WR: mem_we=1, retire=1. Next state FETCH.
- BRANCH: alu_src_b=0, alu_op=01, ext_op=1, npc_sel=01, pc_we=zero, retire=1. Next state FETCH.
- JUMP: pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10, retire=1. Next state FETCH. $31 captures the PC register value (already PC+4) on the same edge the PC is updated.
- JR: pc_we=1, npc_sel=11, retire=1. Next state FETCH.
- Every output not listed for a state is 0.
- Outputs are combinational from the state register plus opcode/funct.

## Timing
- Reset: on the edge where reset=1, state←FETCH. While reset=1, pc_we, ir_we, mem_we, reg_we and retire are forced 0, and state reads 0. The first fetch happens in the first cycle with reset=0.
- Reset mid-instruction aborts it. No write from the aborted instruction occurs in the reset cycle or afterwards.
- CPI:
  - add, sub, ori, lui, sw: 4
  - lw: 5
  - beq, jal, jr: 3
  - UNKNOWN: 2
- retire is asserted for exactly one cycle per instruction.
- No handshakes: memory is assumed single-cycle. The memory data register is loaded every cycle, so it is valid in WB_MEM.

## Test plan
- Reset held 3 cycles, then released → state=0 and all enables 0 during reset. First cycle after release: pc_we=1, ir_we=1, state=0.
- Stream add, ori, lui → each takes 4 cycles with retire in cycle 4. Writeback: reg_dst=01 for add and 00 for ori/lui. ext_op=0 and alu_op=10/11 in EXE_I.
- lw then sw → lw: 5 cycles with states 0,1,4,5,8, wd_sel=01 in state 8. sw: 4 cycles, mem_we=1 only in state 6, ext_op=1 in state 4.
- beq with zero=1, then beq with zero=0 → 3 cycles each. In BRANCH: npc_sel=01 with pc_we=1 for the first and pc_we=0 for the second.
- jal then jr → both 3 cycles. jal: state 10 with pc_we=1, reg_we=1, reg_dst=10, wd_sel=10. jr: state 11 with npc_sel=11.
- opcode 111111 (and nop 0x00000000) → states 0,1,0 with retire in DECODE and no reg_we/mem_we. Reset asserted in MEM_WR → mem_we=0 that cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_we,
   output logic       ir_we,
   output logic [1:0] npc_sel,
   output logic       ext_op,
   output logic       alu_src_b,
   output logic [1:0] alu_op,
   output logic       mem_we,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_sel,
   output logic       retire,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXE_R    = 4'd2,
      S_EXE_I    = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_JR       = 4'd11
   } state_t;

   state_t r_state;

   logic w_rtype, w_add, w_sub, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_jal;

   // Instruction class decode from the IR fields
   always_comb begin
      w_rtype = (opcode == 6'b000000);
      w_add   = w_rtype && (funct == 6'b100000);
      w_sub   = w_rtype && (funct == 6'b100010);
      w_jr    = w_rtype && (funct == 6'b001000);
      w_ori   = (opcode == 6'b001101);
      w_lui   = (opcode == 6'b001111);
      w_lw    = (opcode == 6'b100011);
      w_sw    = (opcode == 6'b101011);
      w_beq   = (opcode == 6'b000100);
      w_jal   = (opcode == 6'b000011);
   end

   // State register and next-state sequencing; illegal codes fall back to FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:  r_state <= S_DECODE;
            S_DECODE: begin
               if (w_add || w_sub)      r_state <= S_EXE_R;
               else if (w_ori || w_lui) r_state <= S_EXE_I;
               else if (w_lw || w_sw)   r_state <= S_MEM_ADDR;
               else if (w_beq)          r_state <= S_BRANCH;
               else if (w_jal)          r_state <= S_JUMP;
               else if (w_jr)           r_state <= S_JR;
               else                     r_state <= S_FETCH;
            end
            S_EXE_R:    r_state <= S_WB_ALU;
            S_EXE_I:    r_state <= S_WB_ALU;
            S_MEM_ADDR: r_state <= w_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   r_state <= S_WB_MEM;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // Control outputs decoded from the current state; reset masks all writes
   always_comb begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      npc_sel   = 2'b00;
      ext_op    = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = 2'b00;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      reg_dst   = 2'b00;
      wd_sel    = 2'b00;
      retire    = 1'b0;
      state     = r_state;
      case (r_state)
         S_FETCH: begin
            ir_we = 1'b1;
            pc_we = 1'b1;
         end
         S_DECODE: begin
            retire = !(w_add || w_sub || w_ori || w_lui || w_lw || w_sw ||
                       w_beq || w_jal || w_jr);
         end
         S_EXE_R: begin
            alu_op = w_sub ? 2'b01 : 2'b00;
         end
         S_EXE_I: begin
            alu_src_b = 1'b1;
            alu_op    = w_lui ? 2'b11 : 2'b10;
         end
         S_WB_ALU: begin
            reg_we  = 1'b1;
            reg_dst = w_rtype ? 2'b01 : 2'b00;
            retire  = 1'b1;
         end
         S_MEM_ADDR: begin
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
         end
         S_WB_MEM: begin
            reg_we = 1'b1;
            wd_sel = 2'b01;
            retire = 1'b1;
         end
         S_MEM_WR: begin
            mem_we = 1'b1;
            retire = 1'b1;
         end
         S_BRANCH: begin
            alu_op  = 2'b01;
            ext_op  = 1'b1;
            npc_sel = 2'b01;
            pc_we   = zero;
            retire  = 1'b1;
         end
         S_JUMP: begin
            pc_we   = 1'b1;
            npc_sel = 2'b10;
            reg_we  = 1'b1;
            reg_dst = 2'b10;
            wd_sel  = 2'b10;
            retire  = 1'b1;
         end
         S_JR: begin
            pc_we   = 1'b1;
            npc_sel = 2'b11;
            retire  = 1'b1;
         end
         default: begin
         end
      endcase
      if (reset) begin
         pc_we  = 1'b0;
         ir_we  = 1'b0;
         mem_we = 1'b0;
         reg_we = 1'b0;
         retire = 1'b0;
         state  = 4'd0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed bench for multicycle_ctrl
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_we, ir_we, ext_op, alu_src_b, mem_we, reg_we, retire;
   logic [1:0] npc_sel, alu_op, reg_dst, wd_sel;
   logic [3:0] state;

   int n_cmp  = 0;
   int n_fail = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_we(pc_we), .ir_we(ir_we), .npc_sel(npc_sel), .ext_op(ext_op),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_we(mem_we), .reg_we(reg_we),
      .reg_dst(reg_dst), .wd_sel(wd_sel), .retire(retire), .state(state)
   );

   always #5 clk = ~clk;

   // Packed view of every output: state, pc_we, ir_we, npc, ext, srcb, aluop, mem_we, reg_we, rdst, wds, retire
   wire [18:0] w_obs = {state, pc_we, ir_we, npc_sel, ext_op, alu_src_b, alu_op,
                        mem_we, reg_we, reg_dst, wd_sel, retire};

   function automatic logic [18:0] e(input logic [3:0] st, input logic pw, input logic iw,
                                     input logic [1:0] np, input logic ex, input logic sb,
                                     input logic [1:0] ao, input logic mw, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] ws, input logic rt);
      return {st, pw, iw, np, ex, sb, ao, mw, rw, rd, ws, rt};
   endfunction

   localparam logic [18:0] V_ZERO   = 19'd0;
   localparam logic [18:0] V_FETCH  = {4'd0, 1'b1, 1'b1, 13'd0};
   localparam logic [18:0] V_DECODE = {4'd1, 15'd0};

   // Called at posedge+1: settle, compare, then advance to the next posedge+1
   task automatic cyc(input string tag, input logic [18:0] exp_v);
      #1;
      n_cmp++;
      assert (w_obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, w_obs, exp_v);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic z);
      opcode = op;
      funct  = fn;
      zero   = z;
   endtask

   initial begin
      reset = 1'b1;
      set_ins(6'd0, 6'd0, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
         #1;
         n_cmp++;
         assert (w_obs === V_ZERO) else begin
            n_fail++;
            $error("FAIL reset_hold: observed %h expected %h", w_obs, V_ZERO);
         end
      end
      reset = 1'b0;

      // add
      set_ins(6'b000000, 6'b100000, 1'b0);
      cyc("add_fetch",  V_FETCH);
      cyc("add_decode", V_DECODE);
      cyc("add_exe",    e(4'd2, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      cyc("add_wb",     e(4'd7, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 2'b01, 2'b00, 1));
      // sub
      set_ins(6'b000000, 6'b100010, 1'b0);
      cyc("sub_fetch",  V_FETCH);
      cyc("sub_decode", V_DECODE);
      cyc("sub_exe",    e(4'd2, 0, 0, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0));
      cyc("sub_wb",     e(4'd7, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 2'b01, 2'b00, 1));
      // ori
      set_ins(6'b001101, 6'd0, 1'b0);
      cyc("ori_fetch",  V_FETCH);
      cyc("ori_decode", V_DECODE);
      cyc("ori_exe",    e(4'd3, 0, 0, 2'b00, 0, 1, 2'b10, 0, 0, 2'b00, 2'b00, 0));
      cyc("ori_wb",     e(4'd7, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 1));
      // lui
      set_ins(6'b001111, 6'd0, 1'b0);
      cyc("lui_fetch",  V_FETCH);
      cyc("lui_decode", V_DECODE);
      cyc("lui_exe",    e(4'd3, 0, 0, 2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b00, 0));
      cyc("lui_wb",     e(4'd7, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 1));
      // lw
      set_ins(6'b100011, 6'd0, 1'b0);
      cyc("lw_fetch",   V_FETCH);
      cyc("lw_decode",  V_DECODE);
      cyc("lw_addr",    e(4'd4, 0, 0, 2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      cyc("lw_rd",      e(4'd5, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      cyc("lw_wb",      e(4'd8, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 2'b00, 2'b01, 1));
      // sw
      set_ins(6'b101011, 6'd0, 1'b0);
      cyc("sw_fetch",   V_FETCH);
      cyc("sw_decode",  V_DECODE);
      cyc("sw_addr",    e(4'd4, 0, 0, 2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      cyc("sw_wr",      e(4'd6, 0, 0, 2'b00, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 1));
      // beq taken / not taken
      set_ins(6'b000100, 6'd0, 1'b1);
      cyc("beq1_fetch", V_FETCH);
      cyc("beq1_decode", V_DECODE);
      cyc("beq1_br",    e(4'd9, 1, 0, 2'b01, 1, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1));
      set_ins(6'b000100, 6'd0, 1'b0);
      cyc("beq0_fetch", V_FETCH);
      cyc("beq0_decode", V_DECODE);
      cyc("beq0_br",    e(4'd9, 0, 0, 2'b01, 1, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1));
      // jal
      set_ins(6'b000011, 6'd0, 1'b0);
      cyc("jal_fetch",  V_FETCH);
      cyc("jal_decode", V_DECODE);
      cyc("jal_jump",   e(4'd10, 1, 0, 2'b10, 0, 0, 2'b00, 0, 1, 2'b10, 2'b10, 1));
      // jr
      set_ins(6'b000000, 6'b001000, 1'b0);
      cyc("jr_fetch",   V_FETCH);
      cyc("jr_decode",  V_DECODE);
      cyc("jr_jr",      e(4'd11, 1, 0, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1));
      // unknown opcode and nop retire in DECODE
      set_ins(6'b111111, 6'd0, 1'b0);
      cyc("unk_fetch",  V_FETCH);
      cyc("unk_decode", e(4'd1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1));
      set_ins(6'b000000, 6'b000000, 1'b0);
      cyc("nop_fetch",  V_FETCH);
      cyc("nop_decode", e(4'd1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1));
      // sw aborted by reset in MEM_WR
      set_ins(6'b101011, 6'd0, 1'b0);
      cyc("swr_fetch",  V_FETCH);
      cyc("swr_decode", V_DECODE);
      cyc("swr_addr",   e(4'd4, 0, 0, 2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0));
      reset = 1'b1;
      cyc("swr_reset_in_wr", V_ZERO);
      cyc("swr_reset_hold",  V_ZERO);
      reset = 1'b0;
      set_ins(6'b001101, 6'd0, 1'b0);
      cyc("post_reset_fetch",  V_FETCH);
      cyc("post_reset_decode", V_DECODE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
